// File: rtl/cdc_strobe_sched.sv
// Round-robin scheduler sharing one cdc_strobe channel among N source-domain requesters.
// Pending strobes are counted per requester and issued with at least GAP cycles between them.
module cdc_strobe_sched #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N-1:0]           req_strb,
  input  logic                   ovf_clr,
  output logic                   out_strb,
  output logic [$clog2(N)-1:0]   out_id,
  output logic [N*CNT_W-1:0]     pending,
  output logic [N-1:0]           ovf,
  output logic                   busy
);

  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned GapW = $clog2(GAP);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StGap} state_e;

  state_e                      state_q, state_d;
  logic [GapW-1:0]             gap_q, gap_d;
  logic [IdW-1:0]              ptr_q, ptr_d;
  logic [N-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [N-1:0]                ovf_q, ovf_d;
  logic                        out_strb_q;
  logic [IdW-1:0]              out_id_q;

  logic [N-1:0]                nz;
  logic [N-1:0]                ovf_evt;
  logic [IdW-1:0]              winner;
  logic                        grant;

  // Arbitration sees registered counts only, so a same-cycle request cannot be granted.
  always_comb begin
    nz     = '0;
    winner = '0;
    for (int i = 0; i < int'(N); i++) begin
      nz[i] = |cnt_q[i];
    end
    // Descending scans leave the lowest qualifying index; the upper range overrides the wrap.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (nz[i] && i <= int'(ptr_q)) winner = IdW'(i);
    end
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (nz[i] && i > int'(ptr_q)) winner = IdW'(i);
    end
    grant = (state_q == StIdle) && en && (|nz);
  end

  always_comb begin
    cnt_d   = cnt_q;
    ovf_evt = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (req_strb[i] && !(grant && winner == IdW'(i))) begin
        if (cnt_q[i] == CntMax) begin
          ovf_evt[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else if (!req_strb[i] && grant && winner == IdW'(i)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
    // A fresh overflow outranks a simultaneous clear.
    ovf_d = (ovf_q & ~{N{ovf_clr}}) | ovf_evt;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StGap;
          gap_d   = GapW'(GAP - 2);
          ptr_d   = winner;
        end
      end
      StGap: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      ptr_q      <= IdW'(N - 1);
      cnt_q      <= '0;
      ovf_q      <= '0;
      out_strb_q <= 1'b0;
      out_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_strb_q <= grant;
      if (grant) out_id_q <= winner;
    end
  end

  assign out_strb = out_strb_q;
  assign out_id   = out_id_q;
  assign pending  = cnt_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != StIdle) || (|nz);

endmodule

// File: tb/tb_cdc_strobe_sched.sv
// Bench for cdc_strobe_sched: directed scenarios plus randomized runs against a queue-free
// counting model and a toggle-synchronizer destination in a slower clock domain.
module tb_cdc_strobe_sched;

  localparam int N   = 4;
  localparam int IW  = $clog2(N);
  localparam int CW  = 2;
  localparam int GP  = 4;
  localparam int CW2 = 4;
  localparam int GP2 = 16;
  localparam int PMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic clk_slow = 1'b0;
  always #5 clk = ~clk;
  always #15 clk_slow = ~clk_slow;

  logic          rst, en, ovf_clr;
  logic [N-1:0]  req_strb;
  logic          out_strb, busy;
  logic [IW-1:0] out_id;
  logic [N*CW-1:0] pending;
  logic [N-1:0]  ovf;

  logic          en2, ovf_clr2;
  logic [N-1:0]  req2;
  logic          out_strb2, busy2;
  logic [IW-1:0] out_id2;
  logic [N*CW2-1:0] pending2;
  logic [N-1:0]  ovf2;

  int tests = 0;
  int fails = 0;

  cdc_strobe_sched #(.N(N), .CNT_W(CW), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .en(en), .req_strb(req_strb), .ovf_clr(ovf_clr),
    .out_strb(out_strb), .out_id(out_id), .pending(pending), .ovf(ovf), .busy(busy)
  );

  cdc_strobe_sched #(.N(N), .CNT_W(CW2), .GAP(GP2)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .req_strb(req2), .ovf_clr(ovf_clr2),
    .out_strb(out_strb2), .out_id(out_id2), .pending(pending2), .ovf(ovf2), .busy(busy2)
  );

  // Destination side of a toggle-based cdc_strobe channel in the ~33 MHz domain.
  logic src_tog = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  int   dst_cnt = 0;
  always @(posedge clk) if (out_strb2) src_tog <= ~src_tog;
  always @(posedge clk_slow) begin
    s1 <= src_tog;
    s2 <= s1;
    s3 <= s2;
    if (s2 != s3) dst_cnt <= dst_cnt + 1;
  end

  // Reference model: counts per requester, a round-robin pointer and the earliest grant cycle.
  int m_pend[N];
  bit m_ovf[N];
  int m_ptr, m_cyc, m_next, m_id;
  bit m_strb;

  task automatic step();
    int win;
    bit evt;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_ovf[i]  = 1'b0;
      end
      m_ptr = N - 1; m_cyc = 0; m_next = 0; m_strb = 1'b0; m_id = 0;
    end else begin
      win = -1;
      if (en && m_cyc >= m_next) begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && m_pend[(m_ptr + k) % N] > 0) win = (m_ptr + k) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        evt = 1'b0;
        if (req_strb[i] && win != i) begin
          if (m_pend[i] == PMAX) evt = 1'b1;
          else m_pend[i]++;
        end else if (!req_strb[i] && win == i) begin
          m_pend[i]--;
        end
        m_ovf[i] = (m_ovf[i] && !ovf_clr) || evt;
      end
      m_strb = (win >= 0);
      if (win >= 0) begin
        m_id   = win;
        m_ptr  = win;
        m_next = m_cyc + GP;
      end
      m_cyc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0;
    req_strb = 4'b1011;
    step();
    step();
    req_strb = '0;
    do_reset();
    tests++;
    if ({out_strb, out_id, pending, ovf, busy} !== '0) begin
      fails++;
      $display("FAIL reset_state: got strb=%b id=%0d pend=%h ovf=%b busy=%b, expected all zero",
               out_strb, out_id, pending, ovf, busy);
    end
    en = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req_strb = 4'b0100;
    step();
    req_strb = '0;
    tests++;
    if (pending[2*CW +: CW] !== 2'd1) begin
      fails++;
      $display("FAIL single_pending_t1: got %0d expected 1", pending[2*CW +: CW]);
    end
    step();
    tests++;
    if (out_strb !== 1'b1 || out_id !== 2'd2 || pending[2*CW +: CW] !== 2'd0) begin
      fails++;
      $display("FAIL single_grant_t2: got strb=%b id=%0d pend=%0d expected 1/2/0",
               out_strb, out_id, pending[2*CW +: CW]);
    end
    step();
    step();
    tests++;
    if (busy !== 1'b1 || out_strb !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_t4: got busy=%b strb=%b expected 1/0", busy, out_strb);
    end
    step();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_idle_t5: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int cyc[$];
    do_reset();
    req_strb = 4'b1111;
    step();
    req_strb = '0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (out_strb) begin
        ids.push_back(int'(out_id));
        cyc.push_back(c);
      end
    end
    tests++;
    if (ids.size() != 4) begin
      fails++;
      $display("FAIL rr_count: got %0d pulses expected 4", ids.size());
    end
    for (int k = 0; k < 4 && k < ids.size(); k++) begin
      tests++;
      if (ids[k] != k) begin
        fails++;
        $display("FAIL rr_order[%0d]: got id %0d expected %0d", k, ids[k], k);
      end
      if (k > 0) begin
        tests++;
        if (cyc[k] - cyc[k-1] != GP) begin
          fails++;
          $display("FAIL rr_spacing[%0d]: got %0d expected %0d", k, cyc[k] - cyc[k-1], GP);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int n1, nother;
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_strb = 4'b0010;
      step();
    end
    req_strb = '0;
    tests++;
    if (pending[1*CW +: CW] !== 2'd3 || ovf !== 4'b0010) begin
      fails++;
      $display("FAIL sat_fill: got pend=%0d ovf=%b expected 3/0010", pending[1*CW +: CW], ovf);
    end
    ovf_clr = 1'b1;
    req_strb = 4'b0010;
    step();
    ovf_clr = 1'b0;
    req_strb = '0;
    tests++;
    if (ovf !== 4'b0010) begin
      fails++;
      $display("FAIL ovf_clr_vs_event: got ovf=%b expected 0010", ovf);
    end
    en = 1'b1;
    n1 = 0;
    nother = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (out_strb) begin
        if (out_id == 2'd1) n1++;
        else nother++;
      end
    end
    tests++;
    if (n1 != 3 || nother != 0) begin
      fails++;
      $display("FAIL sat_drain: got %0d id1 pulses and %0d others expected 3 and 0", n1, nother);
    end
    tests++;
    if (ovf !== 4'b0010) begin
      fails++;
      $display("FAIL ovf_sticky: got ovf=%b expected 0010", ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    tests++;
    if (ovf !== 4'b0000) begin
      fails++;
      $display("FAIL ovf_clear: got ovf=%b expected 0000", ovf);
    end
  endtask

  task automatic test_inc_dec();
    int n0;
    do_reset();
    req_strb = 4'b0001;
    step();
    req_strb = 4'b0001;
    step();
    req_strb = '0;
    tests++;
    if (pending[0 +: CW] !== 2'd1 || out_strb !== 1'b1 || out_id !== 2'd0) begin
      fails++;
      $display("FAIL incdec_same_cycle: got pend=%0d strb=%b id=%0d expected 1/1/0",
               pending[0 +: CW], out_strb, out_id);
    end
    n0 = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_strb && out_id == 2'd0) n0++;
    end
    tests++;
    if (n0 != 2) begin
      fails++;
      $display("FAIL incdec_total: got %0d pulses expected 2", n0);
    end
  endtask

  task automatic test_reset_mid_gap();
    bit seen;
    do_reset();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_strb = 4'b1111;
      step();
    end
    req_strb = '0;
    tests++;
    if (pending !== 8'hFF || ovf !== 4'b1111) begin
      fails++;
      $display("FAIL mid_fill: got pend=%h ovf=%b expected ff/1111", pending, ovf);
    end
    en = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (out_strb) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL mid_first_grant: got no pulse in 10 cycles expected one");
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (pending !== '0 || out_strb !== 1'b0 || ovf !== '0) begin
      fails++;
      $display("FAIL mid_reset: got pend=%h strb=%b ovf=%b expected 0/0/0", pending, out_strb, ovf);
    end
    req_strb = 4'b1000;
    step();
    req_strb = '0;
    step();
    tests++;
    if (out_strb !== 1'b1 || out_id !== 2'd3) begin
      fails++;
      $display("FAIL mid_post_reset: got strb=%b id=%0d expected 1/3", out_strb, out_id);
    end
  endtask

  task automatic test_random_model();
    logic [N*CW-1:0] exp_p;
    logic [N-1:0]    exp_o;
    logic            exp_busy;
    int              shown;
    do_reset();
    shown = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) req_strb[i] = ($urandom_range(0, 3) == 0);
      en      = ($urandom_range(0, 9) != 0);
      ovf_clr = ($urandom_range(0, 19) == 0);
      step();
      exp_busy = (m_cyc < m_next);
      for (int i = 0; i < N; i++) begin
        exp_p[i*CW +: CW] = CW'(m_pend[i]);
        exp_o[i] = m_ovf[i];
        if (m_pend[i] > 0) exp_busy = 1'b1;
      end
      tests++;
      if ({out_strb, out_id, pending, ovf, busy} !== {m_strb, IW'(m_id), exp_p, exp_o, exp_busy}) begin
        fails++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_model cyc %0d: got strb=%b id=%0d pend=%h ovf=%b busy=%b expected %b/%0d/%h/%b/%b",
                   c, out_strb, out_id, pending, ovf, busy, m_strb, m_id, exp_p, exp_o, exp_busy);
        end
      end
    end
    req_strb = '0;
    en = 1'b1;
    ovf_clr = 1'b0;
  endtask

  task automatic test_cdc_end_to_end();
    int sent[N];
    int got[N];
    int total, base, last, bad_gap, r;
    do_reset();
    for (int i = 0; i < N; i++) begin
      sent[i] = 0;
      got[i]  = 0;
    end
    total = 0;
    last = -1000;
    bad_gap = 0;
    base = dst_cnt;
    for (int c = 0; c < 1000; c++) begin
      req2 = '0;
      if (c < 80 && $urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, N - 1);
        if (sent[r] < 12) begin
          req2[r] = 1'b1;
          sent[r]++;
          total++;
        end
      end
      step();
      if (out_strb2) begin
        got[out_id2]++;
        if (c - last < GP2) bad_gap++;
        last = c;
      end
    end
    req2 = '0;
    for (int c = 0; c < 10; c++) step();
    tests++;
    if (dst_cnt - base != total) begin
      fails++;
      $display("FAIL e2e_dest_count: got %0d expected %0d", dst_cnt - base, total);
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (got[i] != sent[i]) begin
        fails++;
        $display("FAIL e2e_per_req[%0d]: got %0d expected %0d", i, got[i], sent[i]);
      end
    end
    tests++;
    if (bad_gap != 0) begin
      fails++;
      $display("FAIL e2e_spacing: got %0d short gaps expected 0", bad_gap);
    end
    tests++;
    if (ovf2 !== '0 || pending2 !== '0 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL e2e_final: got ovf=%b pend=%h busy=%b expected 0/0/0", ovf2, pending2, busy2);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    ovf_clr = 1'b0;
    req_strb = '0;
    en2 = 1'b1;
    ovf_clr2 = 1'b0;
    req2 = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_inc_dec();
    test_reset_mid_gap();
    test_random_model();
    test_cdc_end_to_end();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
